// File: rtl/ctrl_hazard_seq.sv
// ctrl_hazard_seq
// Control-flow hazard sequencer between decode and the PC control logic.
// A branch/call/ret/jreg in decode (with no data hazard) halts fetch, the
// sequencer waits for the matching resolution pulse, then spends one guard
// cycle in RELEASE (flushing IF/ID if the PC was redirected) before
// returning to IDLE.
//
// Optional feature: define HAZARD_TIMEOUT_EN to enable the WAIT watchdog
// and the sticky hazard_err output.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in WAIT, in cycles (2..255)
//   CNT_W           width of the accepted-hazard counter
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_branch/call/ret/jreg          control instruction in decode
//   data_hazard                      blocks acceptance of a new hazard
//   clr_branch/call/ret/jreg         registered resolution pulses
//   pc_src                           PC redirect select at the clear
//   stall_fetch                      hold PC and IF/ID (WAIT, RELEASE)
//   flush_if_id                      one-cycle IF/ID squash in RELEASE
//   hz_type                          latched type: 00 br, 01 call, 10 ret, 11 jreg
//   busy                             state is not IDLE
//   hz_count                         accepted hazards, wraps
//   wait_cycles                      length of last WAIT, saturates at 255
//   hazard_err                       sticky watchdog flag (HAZARD_TIMEOUT_EN)
module ctrl_hazard_seq #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_branch,
  input  logic             id_call,
  input  logic             id_ret,
  input  logic             id_jreg,
  input  logic             data_hazard,
  input  logic             clr_branch,
  input  logic             clr_call,
  input  logic             clr_ret,
  input  logic             clr_jreg,
  input  logic             pc_src,
  output logic             stall_fetch,
  output logic             flush_if_id,
  output logic [1:0]       hz_type,
  output logic             busy,
  output logic [CNT_W-1:0] hz_count,
  output logic [7:0]       wait_cycles
`ifdef HAZARD_TIMEOUT_EN
  ,
  output logic             hazard_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Elaboration-time guard on the watchdog range.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

`ifdef HAZARD_TIMEOUT_EN
  // Forcing the exit when the counter is one short of the limit makes
  // RELEASE start exactly TIMEOUT_CYCLES cycles after WAIT entry.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_VAL  = 8'(TIMEOUT_CYCLES);
`endif

  state_t     state;
  logic [7:0] wait_cnt;
  logic       detect;
  logic [1:0] det_type;
  logic       clr_match;

  assign detect = (id_branch | id_call | id_ret | id_jreg) & ~data_hazard;

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    det_type = 2'b11;
    if (id_branch)    det_type = 2'b00;
    else if (id_call) det_type = 2'b01;
    else if (id_ret)  det_type = 2'b10;
  end

  // Only the resolution pulse that belongs to the latched hazard counts.
  always_comb begin
    clr_match = 1'b0;
    case (hz_type)
      2'b00:   clr_match = clr_branch;
      2'b01:   clr_match = clr_call;
      2'b10:   clr_match = clr_ret;
      default: clr_match = clr_jreg;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      stall_fetch <= 1'b0;
      flush_if_id <= 1'b0;
      hz_type     <= 2'b00;
      hz_count    <= '0;
      wait_cnt    <= 8'd0;
      wait_cycles <= 8'd0;
`ifdef HAZARD_TIMEOUT_EN
      hazard_err  <= 1'b0;
`endif
    end else begin
      flush_if_id <= 1'b0;
      case (state)
        S_IDLE: begin
          if (detect) begin
            state       <= S_WAIT;
            stall_fetch <= 1'b1;
            hz_type     <= det_type;
            hz_count    <= hz_count + CNT_W'(1);
            wait_cnt    <= 8'd0;
          end
        end
        S_WAIT: begin
          if (clr_match) begin
            state       <= S_RELEASE;
            wait_cycles <= wait_cnt;
            flush_if_id <= pc_src;
`ifdef HAZARD_TIMEOUT_EN
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state       <= S_RELEASE;
            wait_cycles <= TIMEOUT_VAL;
            flush_if_id <= 1'b1;
            hazard_err  <= 1'b1;
`endif
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          // Guard cycle: detects are ignored while the PC logic re-enables.
          state       <= S_IDLE;
          stall_fetch <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          stall_fetch <= 1'b0;
        end
      endcase
    end
  end

  assign busy = stall_fetch;

endmodule

// File: tb/tb_ctrl_hazard_seq.sv
module tb_ctrl_hazard_seq;

  localparam int TO  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_branch = 0, id_call = 0, id_ret = 0, id_jreg = 0;
  logic          data_hazard = 0;
  logic          clr_branch = 0, clr_call = 0, clr_ret = 0, clr_jreg = 0;
  logic          pc_src = 0;
  logic          stall_fetch, flush_if_id, busy;
  logic [1:0]    hz_type;
  logic [CW-1:0] hz_count;
  logic [7:0]    wait_cycles;
`ifdef HAZARD_TIMEOUT_EN
  logic          hazard_err;
`endif

  int nvec = 0;
  int nerr = 0;
  int model_count = 0;

  ctrl_hazard_seq #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
`ifdef HAZARD_TIMEOUT_EN
    .hazard_err (hazard_err),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .id_branch  (id_branch),
    .id_call    (id_call),
    .id_ret     (id_ret),
    .id_jreg    (id_jreg),
    .data_hazard(data_hazard),
    .clr_branch (clr_branch),
    .clr_call   (clr_call),
    .clr_ret    (clr_ret),
    .clr_jreg   (clr_jreg),
    .pc_src     (pc_src),
    .stall_fetch(stall_fetch),
    .flush_if_id(flush_if_id),
    .hz_type    (hz_type),
    .busy       (busy),
    .hz_count   (hz_count),
    .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit order everywhere: {jreg, ret, call, branch}.
  task automatic set_ids(input logic [3:0] v);
    {id_jreg, id_ret, id_call, id_branch} = v;
  endtask

  task automatic set_clr(input logic [3:0] v);
    {clr_jreg, clr_ret, clr_call, clr_branch} = v;
  endtask

  // Highest-priority set bit is the lowest index (branch first).
  function automatic logic [1:0] prio(input logic [3:0] ids);
    logic [1:0] r = 2'b00;
    for (int i = 3; i >= 0; i--) if (ids[i]) r = 2'(i);
    return r;
  endfunction

  // One complete hazard: blocked for dh cycles, accepted, clear after
  // 'delay' WAIT cycles with random non-matching clears, RELEASE, IDLE.
  // next_ids are presented from the clear cycle on, to probe the guard.
  task automatic do_hazard(input logic [3:0] ids, input int dh, input int delay,
                           input logic pc, input logic [3:0] next_ids);
    logic [1:0] t;
    logic [3:0] m;
    int         exp_wait;
    t = prio(ids);
    m = 4'(1 << t);
    exp_wait = (delay > 255) ? 255 : delay;
    set_ids(ids);
    data_hazard = 1'b1;
    for (int i = 0; i < dh; i++) begin
      set_clr(4'($urandom_range(0, 15)));
      tick();
      nvec++;
      if (stall_fetch !== 1'b0) begin
        nerr++; $display("FAIL dh_block: stall_fetch=%b want 0", stall_fetch);
      end
    end
    data_hazard = 1'b0;
    set_clr(m);          // clear in the detect cycle must be ignored
    pc_src = 1'b1;
    tick();
    model_count++;
    set_ids(4'b0000);
    nvec++;
    if ({stall_fetch, busy} !== 2'b11) begin
      nerr++; $display("FAIL accept_stall: stall/busy=%b want 11", {stall_fetch, busy});
    end
    nvec++;
    if (hz_type !== t) begin
      nerr++; $display("FAIL hz_type: got %b want %b", hz_type, t);
    end
    nvec++;
    if (hz_count !== CW'(model_count)) begin
      nerr++; $display("FAIL hz_count: got %0d want %0d", hz_count, CW'(model_count));
    end
    for (int d = 0; d < delay; d++) begin
      set_clr(4'($urandom_range(0, 15)) & ~m);
      pc_src = 1'($urandom_range(0, 1));
      tick();
      nvec++;
      if ({stall_fetch, flush_if_id} !== 2'b10) begin
        nerr++; $display("FAIL wait_hold: stall/flush=%b want 10", {stall_fetch, flush_if_id});
      end
    end
    set_clr(m | (4'($urandom_range(0, 15)) & ~m));
    pc_src = pc;
    set_ids(next_ids);
    tick();
    nvec++;
    if ({stall_fetch, flush_if_id} !== {1'b1, pc}) begin
      nerr++; $display("FAIL release: stall/flush=%b want %b", {stall_fetch, flush_if_id}, {1'b1, pc});
    end
    nvec++;
    if (wait_cycles !== 8'(exp_wait)) begin
      nerr++; $display("FAIL wait_cycles: got %0d want %0d", wait_cycles, exp_wait);
    end
    set_clr(4'b0000);
    pc_src = 1'b0;
    tick();
    nvec++;
    if ({stall_fetch, flush_if_id, busy} !== 3'b000) begin
      nerr++; $display("FAIL idle_back: stall/flush/busy=%b want 000", {stall_fetch, flush_if_id, busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    nvec++;
    if ({stall_fetch, flush_if_id, hz_type, busy, hz_count, wait_cycles} !== '0) begin
      nerr++; $display("FAIL reset: outputs=%b want all zero",
                       {stall_fetch, flush_if_id, hz_type, busy, hz_count, wait_cycles});
    end
`ifdef HAZARD_TIMEOUT_EN
    nvec++;
    if (hazard_err !== 1'b0) begin
      nerr++; $display("FAIL reset_err: hazard_err=%b want 0", hazard_err);
    end
`endif
    tick();
    rst_n = 1'b1;
    model_count = 0;
    tick();
  endtask

  task automatic test_taken_branch();
    do_hazard(4'b0001, 0, 2, 1'b1, 4'b0000);
  endtask

  task automatic test_untaken_branch();
    do_hazard(4'b0001, 0, 1, 1'b0, 4'b0000);
  endtask

  task automatic test_data_hazard_prio();
    do_hazard(4'b0110, 3, 3, 1'b1, 4'b0000);
  endtask

  task automatic test_back_to_back();
    do_hazard(4'b0100, 0, 0, 1'b1, 4'b1000);
    do_hazard(4'b1000, 0, 1, 1'b0, 4'b0000);
  endtask

  task automatic test_mid_wait_reset();
    set_ids(4'b0001);
    tick();
    set_ids(4'b0000);
    tick();
    rst_n = 1'b0;
    #2;
    nvec++;
    if ({stall_fetch, flush_if_id, hz_type, busy, hz_count, wait_cycles} !== '0) begin
      nerr++; $display("FAIL async_reset: outputs=%b want all zero",
                       {stall_fetch, flush_if_id, hz_type, busy, hz_count, wait_cycles});
    end
    tick();
    rst_n = 1'b1;
    model_count = 0;
    set_clr(4'b0001);
    pc_src = 1'b1;
    tick();
    set_clr(4'b0000);
    pc_src = 1'b0;
    tick();
    nvec++;
    if ({stall_fetch, flush_if_id, hz_count} !== '0) begin
      nerr++; $display("FAIL dropped_hazard: stall/flush/count=%b want zero",
                       {stall_fetch, flush_if_id, hz_count});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      do_hazard(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 6),
                1'($urandom_range(0, 1)), 4'b0000);
  endtask

`ifndef HAZARD_TIMEOUT_EN
  task automatic test_saturation();
    do_hazard(4'b0010, 0, 300, 1'b1, 4'b0000);
  endtask
`else
  task automatic test_timeout();
    set_ids(4'b0001);
    tick();
    model_count++;
    set_ids(4'b0000);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      nvec++;
      if ({stall_fetch, flush_if_id} !== 2'b10) begin
        nerr++; $display("FAIL to_wait: stall/flush=%b want 10", {stall_fetch, flush_if_id});
      end
    end
    tick();
    nvec++;
    if ({stall_fetch, flush_if_id, hazard_err} !== 3'b111) begin
      nerr++; $display("FAIL to_release: stall/flush/err=%b want 111",
                       {stall_fetch, flush_if_id, hazard_err});
    end
    nvec++;
    if (wait_cycles !== 8'(TO)) begin
      nerr++; $display("FAIL to_wait_cycles: got %0d want %0d", wait_cycles, TO);
    end
    tick();
    do_hazard(4'b0001, 0, 1, 1'b0, 4'b0000);
    nvec++;
    if (hazard_err !== 1'b1) begin
      nerr++; $display("FAIL to_sticky: hazard_err=%b want 1", hazard_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_taken_branch();
    test_untaken_branch();
    test_data_hazard_prio();
    test_back_to_back();
    test_random();
`ifndef HAZARD_TIMEOUT_EN
    test_saturation();
`else
    test_timeout();
`endif
    test_mid_wait_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ctrl_hazard_seq.md
# ctrl_hazard_seq

Sequencer for control-flow hazards between the decode stage and the PC control logic. It detects branch, call, return and register-jump instructions in decode, halts fetch and holds the decode register, waits for the matching resolution pulse, then releases the pipe and flushes the fetch/decode register when the PC was redirected. It sits beside the hazard-clear flops of the PC control logic and drives the pipeline stall and flush enables.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in WAIT, counted in cycles. Range 2..255.
- `CNT_W`, default 16: width of the hazard event counter.

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_branch` in 1: branch instruction in decode.
- `id_call` in 1: call instruction in decode.
- `id_ret` in 1: return instruction in decode.
- `id_jreg` in 1: register-jump instruction in decode.
- `data_hazard` in 1: data hazard active; blocks acceptance of a new control hazard.
- `clr_branch` in 1: registered resolution pulse for a branch.
- `clr_call` in 1: registered resolution pulse for a call.
- `clr_ret` in 1: registered resolution pulse for a return.
- `clr_jreg` in 1: registered resolution pulse for a register jump.
- `pc_src` in 1: PC redirect select, sampled in the same cycle as the accepted clear.
- `stall_fetch` out 1: hold the PC and the fetch/decode register.
- `flush_if_id` out 1: one-cycle pulse that squashes the fetch/decode register.
- `hz_type` out 2: latched hazard type. 00 = branch, 01 = call, 10 = ret, 11 = jreg.
- `busy` out 1: state is not IDLE.
- `hz_count` out CNT_W: number of accepted hazards; wraps modulo 2^CNT_W.
- `wait_cycles` out 8: length of the last WAIT period; saturates at 255.
- `hazard_err` out 1: sticky watchdog flag; exists only when `HAZARD_TIMEOUT_EN` is defined.

## Operation
- States: IDLE, WAIT, RELEASE. State encoding is 2 bits.
- Reset values: state = IDLE, `stall_fetch` = 0, `flush_if_id` = 0, `hz_type` = 00, `busy` = 0, `hz_count` = 0, `wait_cycles` = 0, `hazard_err` = 0.
- **IDLE:**
  - A detect is accepted when any `id_*` is high and `data_hazard` = 0.
  - Priority when several are high: branch > call > ret > jreg.
  - On accept: latch `hz_type`, increment `hz_count`, clear the internal wait counter, go to WAIT.
  - If `data_hazard` = 1, the detect is ignored. The instruction stays in decode and is retried the next cycle.
- **WAIT:**
  - The internal wait counter increments each cycle and saturates at 255.
  - Only the clear matching `hz_type` is accepted. Non-matching clears are ignored.
  - On the matching clear: copy the wait counter to `wait_cycles`, register `flush_if_id` = `pc_src`, go to RELEASE.
  - `id_*` inputs are ignored in this state.
- **RELEASE:**
  - Lasts exactly 1 cycle, then goes to IDLE.
  - New detects are ignored in this state. This guard cycle covers the two-cycle branch re-enable of the PC logic.
- `stall_fetch` is registered: high in WAIT and RELEASE, low in IDLE.
- `busy` equals `stall_fetch`.

## Timing
- Detect accepted in cycle N: `stall_fetch` and `busy` go high in cycle N+1.
- Matching clear in cycle M: RELEASE in cycle M+1, with `flush_if_id` = `pc_src` sampled at M.
- Cycle M+2: IDLE, `stall_fetch` = 0. A new detect can be accepted in M+2.
- Minimum hazard occupancy is 3 cycles: clear arriving in the first WAIT cycle.
- If a clear arrives in the same cycle as the detect (state IDLE), it is ignored.
- Asserting `rst_n` mid-operation returns everything to reset values immediately, with no flush pulse. A pending hazard is dropped.
- `hz_count` wraps from 2^CNT_W-1 to 0.

## Configuration
- **`HAZARD_TIMEOUT_EN` defined:**
  - If the wait counter reaches `TIMEOUT_CYCLES` in WAIT with no matching clear, force RELEASE with `flush_if_id` = 1.
  - Set `hazard_err` = 1. It stays high until reset.
  - Load `wait_cycles` = `TIMEOUT_CYCLES`.
- **Not defined:** no watchdog, WAIT can last indefinitely, and the `hazard_err` port is absent.

## Test plan
- Branch with `pc_src` = 1: `id_branch` at cycle 2, `clr_branch` at cycle 5 → `stall_fetch` high in cycles 3..6, `flush_if_id` high only in cycle 6, `wait_cycles` = 2, `hz_count` = 1.
- Untaken branch, `pc_src` = 0 at the clear → `flush_if_id` stays 0 throughout; `stall_fetch` is released 2 cycles after the clear.
- `id_call` and `id_ret` high together with `data_hazard` = 1 for 3 cycles, then 0 → acceptance is delayed 3 cycles; `hz_type` = 01; `clr_ret` arriving during WAIT is ignored; `clr_call` completes the hazard.
- Back-to-back: a second `id_jreg` held during RELEASE → not accepted in RELEASE; accepted in the IDLE cycle that follows; `hz_count` = 2.
- With `HAZARD_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, no clear → RELEASE entered 8 cycles after WAIT entry, `flush_if_id` = 1, `hazard_err` = 1 and sticky, `wait_cycles` = 8.
- `rst_n` pulled low for 1 cycle mid-WAIT → all outputs return to reset values asynchronously; a later clear pulse produces no flush.
